// File: rtl/operand_seg_encoder.sv
// Two-operand binary to seven-segment encoder.
// Sequential double-dabble, one shift per clock, atomic output update.
module operand_seg_encoder #(
  parameter bit BLANK_LZ = 1'b1,
  parameter bit DASH_OVF = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] valA,
  input  logic [6:0] valB,
  output logic       busy,
  output logic       done,
  output logic [7:0] outA10,
  output logic [7:0] outA1,
  output logic [7:0] outB10,
  output logic [7:0] outB1
);

  typedef enum logic [1:0] {
    IDLE,
    CONV_A,
    CONV_B,
    UPDATE
  } state_t;

  state_t     state;
  logic [6:0] sh;
  logic [6:0] opb;
  logic       ovfa;
  logic       ovfb;
  logic [3:0] bt;
  logic [3:0] bo;
  logic [3:0] tensa;
  logic [3:0] onesa;
  logic [2:0] cnt;

  logic [3:0] adjt;
  logic [3:0] adjo;
  logic [3:0] nt;
  logic [3:0] no;

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // tens nibble holds (value/10) mod 10; the hundreds bit is dropped
  function automatic logic [15:0] pair(
    input logic       ovf,
    input logic [3:0] t,
    input logic [3:0] o
  );
    logic [15:0] p;
    if (ovf && DASH_OVF)
      p = {8'hBF, 8'hBF};
    else if (!ovf && BLANK_LZ && t == 4'd0)
      p = {8'hFF, seg(o)};
    else
      p = {seg(t), seg(o)};
    return p;
  endfunction

  // one double-dabble step: add-3 correction then shift left
  always_comb begin
    adjt = (bt >= 4'd5) ? bt + 4'd3 : bt;
    adjo = (bo >= 4'd5) ? bo + 4'd3 : bo;
    nt   = {adjt[2:0], adjo[3]};
    no   = {adjo[2:0], sh[6]};
  end

  // control FSM, conversion datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sh     <= '0;
      opb    <= '0;
      ovfa   <= 1'b0;
      ovfb   <= 1'b0;
      bt     <= '0;
      bo     <= '0;
      tensa  <= '0;
      onesa  <= '0;
      cnt    <= '0;
      outA10 <= 8'hFF;
      outA1  <= 8'hFF;
      outB10 <= 8'hFF;
      outB1  <= 8'hFF;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            sh    <= valA;
            opb   <= valB;
            ovfa  <= valA > 7'd99;
            ovfb  <= valB > 7'd99;
            bt    <= '0;
            bo    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV_A;
          end
        end
        CONV_A: begin
          if (cnt == 3'd6) begin
            tensa <= nt;
            onesa <= no;
            sh    <= opb;
            bt    <= '0;
            bo    <= '0;
            cnt   <= '0;
            state <= CONV_B;
          end else begin
            sh  <= {sh[5:0], 1'b0};
            bt  <= nt;
            bo  <= no;
            cnt <= cnt + 3'd1;
          end
        end
        CONV_B: begin
          sh  <= {sh[5:0], 1'b0};
          bt  <= nt;
          bo  <= no;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd6) begin
            cnt   <= '0;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          {outA10, outA1} <= pair(ovfa, tensa, onesa);
          {outB10, outB1} <= pair(ovfb, bt, bo);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
